// File: rtl/uart_tx.sv
// 8051-style UART transmitter: serialises a byte written to SBUF onto txd,
// paced by baud-counter TC pulses; supports sync mode 0 and async modes 1-3.
module uart_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_n,
    input  logic [7:0] AB,
    input  logic [7:0] din,
    input  logic [1:0] SM,
    input  logic       TB8,
    input  logic       TC,
    input  logic       ti_clr,
    output logic       txd,
    output logic       sclk,
    output logic       TEN,
    output logic       TI,
    output logic       busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [7:0]  SBUF_ADDR = 8'h99;
    localparam logic [CNT_W-1:0] TC_LAST  = CNT_W'(15);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(7);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        BIT9   = 3'd3,
        STOP   = 3'd4,
        SHIFT0 = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       mode_q, mode_d;
    logic             tb8_q, tb8_d;
    logic [CNT_W-1:0] tc_cnt_q, tc_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             txd_d, sclk_d, ten_d, ti_set;
    logic             accept, bit_end;

    assign accept  = !wr_n && (AB == SBUF_ADDR) && (state_q == IDLE);
    assign bit_end = TC && (tc_cnt_q == TC_LAST);
    assign busy    = TEN;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            mode_q    <= '0;
            tb8_q     <= 1'b0;
            tc_cnt_q  <= '0;
            bit_cnt_q <= '0;
            txd       <= 1'b1;
            sclk      <= 1'b1;
            TEN       <= 1'b0;
            TI        <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            mode_q    <= mode_d;
            tb8_q     <= tb8_d;
            tc_cnt_q  <= tc_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            txd       <= txd_d;
            sclk      <= sclk_d;
            TEN       <= ten_d;
            TI        <= ti_set | (TI & ~ti_clr);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        mode_d    = mode_q;
        tb8_d     = tb8_q;
        tc_cnt_d  = tc_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (state_q != IDLE && TC) begin
            tc_cnt_d = tc_cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = din;
                    mode_d    = SM;
                    tb8_d     = TB8;
                    tc_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = (SM == 2'd0) ? SHIFT0 : START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = (mode_q inside {2'd2, 2'd3}) ? BIT9 : STOP;
                    end
                end
            end
            BIT9: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            SHIFT0: begin
                // Second TC of each bit period completes the bit
                if (TC && tc_cnt_q[0]) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == BIT_LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the next state
    always_comb begin
        txd_d  = 1'b1;
        sclk_d = 1'b1;
        ten_d  = (state_d != IDLE);
        ti_set = (state_q != IDLE) && (state_d == IDLE);
        case (state_d)
            START:  txd_d = 1'b0;
            DATA:   txd_d = shift_d[0];
            BIT9:   txd_d = tb8_d;
            SHIFT0: begin
                txd_d = shift_d[0];
                if (state_q == SHIFT0) begin
                    sclk_d = TC ? tc_cnt_q[0] : sclk;
                end
            end
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of frames checked against a
// scoreboard of expected txd bits, plus reset and TI-priority sequences.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n, wr_n, TB8, TC, ti_clr;
    logic [7:0] AB, din;
    logic [1:0] SM;
    logic       txd, sclk, TEN, TI, busy;

    uart_tx dut (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .AB(AB), .din(din), .SM(SM),
        .TB8(TB8), .TC(TC), .ti_clr(ti_clr), .txd(txd), .sclk(sclk),
        .TEN(TEN), .TI(TI), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sm;
        logic [7:0] data;
        logic       tb8;
        int         exp_tc;    // expected frame length in TC pulses
        int         ign_at;    // TC index of an ignored write (0 = none)
        int         clr_mode;  // 1: ti_clr with final TC, 2: ti_clr one cycle later
        int         rst_at;    // TC index of a mid-frame reset (0 = none)
    } vec_t;

    vec_t vecs[8];
    logic exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cur_vec  = -1;
    logic exp_ti   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %0h expected %0h", cur_vec, nm, act, exp);
        end
    endtask

    task automatic pop_chk(input string nm);
        logic b;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL vec%0d %s: scoreboard empty, txd=%0b", cur_vec, nm, txd);
        end else begin
            b = exp_q.pop_front();
            chk(nm, 32'(txd), 32'(b));
        end
    endtask

    // Expected txd bits of one frame, in transmission order
    task automatic push_frame(input logic [1:0] sm, input logic [7:0] d, input logic t8);
        if (sm != 2'd0) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (sm >= 2'd2) exp_q.push_back(t8);
        if (sm != 2'd0) exp_q.push_back(1'b1);
    endtask

    // Called at a negedge; returns at a negedge
    task automatic cpu_write(input logic [7:0] d, input logic [1:0] sm, input logic t8);
        AB = 8'h99; din = d; SM = sm; TB8 = t8; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
    endtask

    task automatic tc_pulse(input int gap, input logic clr);
        TC = 1'b1; ti_clr = clr;
        @(negedge clk);
        TC = 1'b0; ti_clr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v);
        int total;
        total = v.exp_tc;
        exp_q.delete();
        push_frame(v.sm, v.data, v.tb8);
        cpu_write(v.data, v.sm, v.tb8);
        SM = ~v.sm; TB8 = ~v.tb8;
        chk("ten_start", 32'(TEN), 32'd1);
        chk("busy_start", 32'(busy), 32'd1);
        chk("sclk_start", 32'(sclk), 32'd1);
        if (v.sm == 2'd0) chk("txd_m0_start", 32'(txd), 32'(v.data[0]));
        else pop_chk("start_bit");
        for (int k = 1; k <= total; k++) begin
            tc_pulse((k == total) ? 0 : 2, (k == total) && (v.clr_mode == 1));
            if (k == v.rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_txd", 32'(txd), 32'd1);
                chk("rst_ten", 32'(TEN), 32'd0);
                chk("rst_ti", 32'(TI), 32'd0);
                chk("rst_sclk", 32'(sclk), 32'd1);
                @(negedge clk);
                rst_n = 1'b1;
                exp_ti = 1'b0;
                exp_q.delete();
                return;
            end
            if (k == total - 1) begin
                chk("ten_before_end", 32'(TEN), 32'd1);
                chk("ti_before_end", 32'(TI), 32'(exp_ti));
            end
            if (v.sm == 2'd0) begin
                if (k % 2 == 1) begin
                    chk("sclk_low", 32'(sclk), 32'd0);
                    pop_chk("m0_bit");
                end else begin
                    chk("sclk_high", 32'(sclk), 32'd1);
                end
            end else if (k % 16 == 0 && k < total) begin
                pop_chk("async_bit");
                chk("sclk_async", 32'(sclk), 32'd1);
            end
            if (k == v.ign_at) begin
                cpu_write(8'h00, 2'b00, 1'b0);
                chk("busy_after_ign_wr", 32'(busy), 32'd1);
            end
        end
        chk("ten_end", 32'(TEN), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("ti_end", 32'(TI), 32'd1);
        chk("txd_end", 32'(txd), 32'd1);
        chk("sclk_end", 32'(sclk), 32'd1);
        exp_ti = 1'b1;
        if (v.clr_mode == 2) begin
            ti_clr = 1'b1;
            @(negedge clk);
            ti_clr = 1'b0;
            chk("ti_after_clr", 32'(TI), 32'd0);
            exp_ti = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd1, 8'hA5, 1'b0, 160, 80, 0, 0};
        vecs[1] = '{2'd3, 8'h3C, 1'b1, 176, 0, 1, 0};
        vecs[2] = '{2'd0, 8'h81, 1'b0, 16, 0, 2, 0};
        vecs[3] = '{2'd2, 8'h5A, 1'b0, 176, 0, 2, 0};
        vecs[4] = '{2'd1, 8'h00, 1'b1, 160, 0, 2, 50};
        vecs[5] = '{2'd1, 8'hC3, 1'b0, 160, 0, 0, 0};
        vecs[6] = '{2'd0, 8'h6E, 1'b1, 16, 0, 0, 0};
        vecs[7] = '{2'd3, 8'hFF, 1'b0, 176, 0, 2, 0};

        rst_n = 1'b0; wr_n = 1'b1; AB = 8'h00; din = 8'h00;
        SM = 2'd0; TB8 = 1'b0; TC = 1'b0; ti_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_sclk", 32'(sclk), 32'd1);
        chk("reset_ten", 32'(TEN), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ti", 32'(TI), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) tc_pulse(2, 1'b0);
        chk("idle_tc_txd", 32'(txd), 32'd1);
        chk("idle_tc_sclk", 32'(sclk), 32'd1);
        chk("idle_tc_ten", 32'(TEN), 32'd0);
        chk("idle_tc_ti", 32'(TI), 32'd0);

        // Write to another address must not start a frame
        AB = 8'h98; din = 8'h55; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        chk("other_addr_ten", 32'(TEN), 32'd0);

        for (int i = 0; i < 8; i++) begin
            cur_vec = i;
            run_frame(vecs[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
